// File: rtl/num_stream_tx_pkg.sv
// Shared definitions for the number-stream transmitter.
//   - state_t      : FSM encoding (S_IDLE=0, S_SEND=1, S_DONE=2)
//   - DEF_WIDTH    : default data word width, shared with largest_no_fsm benches
//   - DEF_DEPTH    : default buffer capacity in words
//   - DEF_ADDR_W   : log2(DEF_DEPTH)
package num_stream_tx_pkg;

  localparam int DEF_WIDTH  = 2;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/num_stream_buf.sv
// DEPTH x WIDTH register array holding the words queued for transmission.
// Ports:
//   clk   : rising-edge clock for the write port
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : word stored at raddr
// Contents are not reset; the owner tracks which entries are valid.
module num_stream_buf #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/num_stream_tx.sv
// Buffered transmitter feeding the running-largest tracker. The host loads
// up to DEPTH words while idle, pulses start, and the words are replayed in
// load order, one per accepted valid/ready handshake. A running maximum of
// the accepted words is kept for cross-checking the tracker.
//
// Handshake: a word transfers on every rising edge where data_valid and
// data_ready are both high. data_valid depends only on registered state, so
// there is no combinational path from data_ready to data_valid, and
// data_out holds steady while data_ready is low.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en      : load strobe (IDLE only, dropped when full)
//   wr_data    : word to load
//   full       : count == DEPTH
//   start      : begin transmission (IDLE only, needs count > 0)
//   busy       : state is SEND or DONE
//   data_out   : current word in SEND, else 0
//   data_valid : high throughout SEND
//   data_ready : sink acceptance
//   done       : one-cycle pulse after the last word is accepted
//   count      : words loaded
//   max_sent   : maximum of words accepted in the current transmission
module num_stream_tx
  import num_stream_tx_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  input  logic              start,
  output logic              busy,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [WIDTH-1:0]  max_sent
);

  localparam int CNT_W = ADDR_W + 1;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [WIDTH-1:0]    rd_word;
  logic                write_ok;
  logic                start_ok;
  logic                accept;
  logic                last_word;

  assign full = (count == CNT_W'(DEPTH));

  // Both strobes are qualified by IDLE; start looks at the count before any
  // same-cycle write lands, so a write alongside start joins the run only
  // when at least one word was already loaded.
  assign write_ok  = (state == S_IDLE) && wr_en && !full;
  assign start_ok  = (state == S_IDLE) && start && (count != '0);
  assign accept    = (state == S_SEND) && data_ready;
  assign last_word = ({1'b0, rd_ptr} == (count - CNT_W'(1)));

  num_stream_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk  (clk),
    .we   (write_ok),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    data_valid = 1'b0;
    done       = 1'b0;
    data_out   = '0;
    unique case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        busy       = 1'b1;
        data_valid = 1'b1;
        data_out   = rd_word;
        if (accept && last_word) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      max_sent <= '0;
    end else begin
      if (write_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        count  <= count + CNT_W'(1);
      end
      if (start_ok) begin
        rd_ptr   <= '0;
        max_sent <= '0;
      end
      if (accept) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        if (rd_word > max_sent) begin
          max_sent <= rd_word;
        end
      end
      // Leaving DONE empties the buffer; max_sent is kept for inspection.
      if (state == S_DONE) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_num_stream_tx.sv
// Directed bench for num_stream_tx: loads hand-picked word sequences,
// transmits them with various ready patterns and checks every output
// against expected values held in the bench.
module tb_num_stream_tx;

  localparam int W = 2;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         full;
  logic         start;
  logic         busy;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         data_ready;
  logic         done;
  logic [A:0]   count;
  logic [W-1:0] max_sent;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mdl_max;
  int           n_vec;
  int           n_err;

  num_stream_tx #(.WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .start     (start),
    .busy      (busy),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .done      (done),
    .count     (count),
    .max_sent  (max_sent)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: observed unexpected condition expected none", tag);
  endtask

  // driver tasks; all are entered and left at a falling edge
  task automatic load_word(input logic [W-1:0] w, input bit taken);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge clk);
    wr_en   = 1'b0;
    if (taken) exp_q.push_back(w);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consume the transmission, checking each word against exp_q and max_sent
  // against the max of words accepted on earlier edges.
  task automatic run_tx(input int stall, input bit poke_wr, input int exp_count);
    int cyc = 0;
    bit seen_done = 0;
    mdl_max = '0;
    while (!seen_done && cyc < 100) begin
      data_ready = (stall == 0);
      if (stall > 0) stall--;
      wr_en   = poke_wr && data_valid;
      wr_data = 2'd3;
      if (data_valid) begin
        chk("max_sent_run", max_sent, mdl_max);
        chk("count_in_send", count, exp_count);
        chk("busy_in_send", busy, 1);
        if (exp_q.size() == 0) fail_now("extra_word");
        else begin
          chk("data_out", data_out, exp_q[0]);
          if (data_ready) begin
            if (exp_q[0] > mdl_max) mdl_max = exp_q[0];
            void'(exp_q.pop_front());
          end
        end
      end else if (done) begin
        seen_done = 1;
        chk("busy_in_done", busy, 1);
        chk("data_out_in_done", data_out, 0);
      end else begin
        fail_now("no_valid_no_done");
      end
      @(negedge clk);
      cyc++;
    end
    wr_en      = 1'b0;
    data_ready = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("words_left", exp_q.size(), 0);
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);
    chk("count_cleared", count, 0);
    chk("max_sent_hold", max_sent, mdl_max);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    start      = 1'b0;
    data_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_max", max_sent, 0);
    chk("rst_data", data_out, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: seven words, sink always ready
    load_word(2'd0, 1); load_word(2'd0, 1); load_word(2'd1, 1); load_word(2'd0, 1);
    load_word(2'd2, 1); load_word(2'd1, 1); load_word(2'd3, 1);
    chk("t1_count", count, 7);
    chk("t1_full", full, 0);
    chk("t1_idle_valid", data_valid, 0);
    pulse_start();
    chk("t1_valid_lat1", data_valid, 1);
    run_tx(0, 0, 7);
    chk("t1_max_final", max_sent, 3);

    // 2: two words, sink stalls three cycles
    load_word(2'd2, 1); load_word(2'd1, 1);
    chk("t2_count", count, 2);
    pulse_start();
    run_tx(3, 0, 2);
    chk("t2_max_final", max_sent, 2);

    // 3: fill to capacity, extra write dropped
    load_word(2'd3, 1); load_word(2'd2, 1); load_word(2'd1, 1); load_word(2'd0, 1);
    load_word(2'd3, 1); load_word(2'd2, 1); load_word(2'd1, 1); load_word(2'd0, 1);
    chk("t3_full", full, 1);
    chk("t3_count8", count, 8);
    load_word(2'd3, 0);
    chk("t3_count_after_9th", count, 8);
    chk("t3_full_after_9th", full, 1);
    pulse_start();
    run_tx(0, 0, 8);
    chk("t3_max_final", max_sent, 3);

    // 4: start with empty buffer is ignored, also with a simultaneous write
    pulse_start();
    chk("t4_busy_empty", busy, 0);
    chk("t4_valid_empty", data_valid, 0);
    @(negedge clk);
    chk("t4_busy_empty2", busy, 0);
    wr_en = 1'b1; wr_data = 2'd1; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    exp_q.push_back(2'd1);
    chk("t4_count_prewrite_start", count, 1);
    chk("t4_busy_prewrite_start", busy, 0);
    chk("t4_valid_prewrite_start", data_valid, 0);

    // 6: write + start together with count=1, writes during SEND ignored
    wr_en = 1'b1; wr_data = 2'd3; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    exp_q.push_back(2'd3);
    chk("t6_valid", data_valid, 1);
    run_tx(0, 1, 2);
    chk("t6_max_final", max_sent, 3);

    // 5: reset in the middle of a transmission
    load_word(2'd1, 1); load_word(2'd2, 1); load_word(2'd3, 1);
    load_word(2'd0, 1); load_word(2'd1, 1);
    pulse_start();
    data_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_mid_data", data_out, 3);
    chk("t5_mid_max", max_sent, 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", data_valid, 0);
    chk("t5_async_data", data_out, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_done", done, 0);
    chk("t5_async_count", count, 0);
    chk("t5_async_max", max_sent, 0);
    @(negedge clk);
    rst        = 1'b0;
    data_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_post_done", done, 0);
    chk("t5_post_busy", busy, 0);
    chk("t5_post_count", count, 0);
    load_word(2'd2, 1); load_word(2'd3, 1); load_word(2'd1, 1);
    chk("t5_reload_count", count, 3);
    pulse_start();
    run_tx(1, 0, 3);
    chk("t5_reload_max", max_sent, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
